dir_chan_merge: RTL and testbench
=================================

# dir_chan_merge

Parametrised successor to the single-direction bus interface test blocks. It merges `CHANNELS` independent writer-side valid/ready streams into one reader-side stream. Each channel has its own `DEPTH`-entry FIFO, and the output side uses a registered output stage with round-robin arbitration. It sits between several producer modules and one consumer, so modport-style direction checking can be exercised with real handshakes and buffering.

## Interface
Parameters:
- `WIDTH`, 8, data bits per word (≥1)
- `DEPTH`, 4, entries per channel FIFO (power of two, ≥2)
- `CHANNELS`, 2, number of input channels (≥2)
- `CW` (derived, not overridable) = `$clog2(CHANNELS)`

Ports:
- `clk`  input  1  single clock; all state updates on rising edge
- `rst`  input  1  reset, asynchronous, active-high
- `flush`  input  1  synchronous clear of all buffered data
- `in_valid`  input  CHANNELS  per-channel word-present strobe
- `in_ready`  output  CHANNELS  per-channel FIFO-not-full
- `in_data`  input  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- `out_valid`  output  1  output register holds a word
- `out_ready`  input  1  consumer accepts word
- `out_data`  output  WIDTH  word in output register
- `out_chan`  output  CW  source channel of `out_data`
- `level`  output  CHANNELS*($clog2(DEPTH)+1)  per-channel FIFO occupancy

## Operation
- **Push:** channel c writes on an edge where `in_valid[c] && in_ready[c]`.
- **in_ready:** `in_ready[c] = (level_c != DEPTH)`. It is derived from registered occupancy only, with no combinational path from `out_ready`. A full FIFO therefore refuses a push even in a cycle where it is popped.
- **Load:** the output register loads when it is empty or is being emptied this edge (`out_valid && out_ready`), provided at least one FIFO is non-empty.
  - Winner is the first non-empty channel scanning `last+1, last+2, …` modulo CHANNELS, where `last` is the previous winner.
  - Winner's head word and index go to `out_data`/`out_chan`. The winner's FIFO pops and `last` updates.
- **Stall:** while `out_valid && !out_ready`, `out_data` and `out_chan` are held stable and no FIFO pops.
- **Simultaneous push/pop, same channel:** both happen and level is unchanged. Push into an empty FIFO is not visible to the arbiter until the next edge (no bypass).
- **Occupancy:** `level_c` = push − pop, range 0..DEPTH. Read/write pointers are `$clog2(DEPTH)` bits and wrap naturally.
- **flush:** takes priority over everything on that edge.
  - All levels and pointers go to 0 and `out_valid` goes to 0. `last` = CHANNELS-1, so channel 0 has first priority.
  - Pushes offered on the flush edge are discarded.
- **Reset:** clears the same state as flush, asynchronously. Storage RAM contents need no reset.

## Timing
- **Reset values:** `in_ready` all 1, `out_valid` 0, `out_data` 0, `out_chan` 0, `level` all 0.
- **Latency:** a word pushed on edge E into an empty channel, with the output register empty, gives `out_valid` = 1 after edge E+1.
- **Throughput:** one word per cycle on the output when `out_ready` is held high and any FIFO is non-empty.
- **Per channel:** at most one word per cycle.
- **Ordering:** strict FIFO within a channel. Across channels, fairness is such that any non-empty channel is served within CHANNELS consecutive output transfers.
- **`level`:** updates on the edge after the push/pop.
- **Reset mid-operation:** all outputs reach reset values immediately on `rst` assertion, independent of `clk`. Operation resumes on the first edge after deassertion.

## Test plan
- **Reset/idle:** assert `rst` mid-stream with words buffered → `out_valid` = 0, all `level` = 0, `in_ready` = all 1 without a clock edge. After release, nothing emerges.
- **Single channel, full:**
  - CHANNELS=2, DEPTH=4, `out_ready` = 0. Push 0x11, 0x22, 0x33, 0x44, 0x55 on ch0 → first word loads the output register. Level reaches 4 after 0x55 is accepted, and `in_ready[0]` then drops.
  - Raise `out_ready` → output is 0x11, 0x22, 0x33, 0x44, 0x55 in order, out_chan = 0.
- **Round-robin:** preload ch0 with A0, A1, A2 and ch1 with B0, B1, B2, then hold `out_ready` = 1 → output sequence is A0, B0, A1, B1, A2, B2 with out_chan 0, 1, 0, 1, 0, 1.
- **Backpressure stability:** `out_valid` = 1 with data 0x5A and `out_ready` held low 3 cycles while ch1 pushes → `out_data` = 0x5A and `out_chan` constant throughout. The next word appears on the edge after the `out_ready` handshake.
- **Full with simultaneous pop:** ch0 at level 4, `out_ready` = 1, `in_valid[0]` = 1 → `in_ready[0]` = 0 that cycle, no push, level goes 4→3. Push accepted the following cycle.
- **Flush:** flush with ch0 at level 2, ch1 at level 3, `out_valid` = 1, and a concurrent push on ch1 → next cycle all levels 0, `out_valid` = 0. The pushed word never appears, and a subsequent push on ch1 then ch0 in the same cycle outputs ch0 first.

Source files
------------

// File: rtl/dir_chan_merge.sv
// Merges CHANNELS valid/ready input streams into one output stream.
// Each channel has its own DEPTH-entry FIFO; a registered output stage picks channels round-robin.
module dir_chan_merge #(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 4,
    parameter  int CHANNELS = 2,
    localparam int CW       = $clog2(CHANNELS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [CHANNELS-1:0]                    in_valid,
    output logic [CHANNELS-1:0]                    in_ready,
    input  logic [CHANNELS*WIDTH-1:0]              in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [WIDTH-1:0]                       out_data,
    output logic [CW-1:0]                          out_chan,
    output logic [CHANNELS*($clog2(DEPTH)+1)-1:0]  level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [CHANNELS-1:0][PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CHANNELS-1:0][LW-1:0] lvl_q, lvl_d;
    logic                        out_valid_q, out_valid_d;
    logic [WIDTH-1:0]            out_data_q, out_data_d;
    logic [CW-1:0]               out_chan_q, out_chan_d;
    logic [CW-1:0]               last_q, last_d;

    logic [WIDTH-1:0]            mem [CHANNELS][DEPTH];

    logic [CHANNELS-1:0]         push, pop, nonempty;
    logic                        found, load;
    logic [CW-1:0]               win;

    // Ready comes only from registered occupancy, so a full FIFO refuses a push even while popping.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            in_ready[c] = (lvl_q[c] != LW'(DEPTH));
            nonempty[c] = (lvl_q[c] != '0);
            push[c]     = in_valid[c] && in_ready[c] && !flush;
        end
    end

    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = (int'(last_q) + i) % CHANNELS;
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                win   = CW'(idx);
            end
        end
    end

    always_comb begin
        load = found && (!out_valid_q || out_ready) && !flush;
        for (int c = 0; c < CHANNELS; c++)
            pop[c] = load && (win == CW'(c));
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        lvl_d       = lvl_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        last_d      = last_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (push[c]) wptr_d[c] = wptr_q[c] + PW'(1);
            if (pop[c])  rptr_d[c] = rptr_q[c] + PW'(1);
            if (push[c] && !pop[c])      lvl_d[c] = lvl_q[c] + LW'(1);
            else if (!push[c] && pop[c]) lvl_d[c] = lvl_q[c] - LW'(1);
        end
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = mem[win][rptr_q[win]];
            out_chan_d  = win;
            last_d      = win;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            lvl_d       = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_chan_d  = '0;
            last_d      = CW'(CHANNELS - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            lvl_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            last_q      <= CW'(CHANNELS - 1);
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            lvl_q       <= lvl_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            last_q      <= last_d;
        end
    end

    // Storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++)
            if (push[c]) mem[c][wptr_q[c]] <= in_data[c*WIDTH +: WIDTH];
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign level     = lvl_q;
endmodule

// File: tb/tb_dir_chan_merge.sv
// Bench for dir_chan_merge: table vectors, hand-written corner sequences, and random traffic
// compared against a queue-based reference model.
module tb_dir_chan_merge;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CH    = 2;
    localparam int CW    = $clog2(CH);
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [CH-1:0]        in_valid;
    logic [CH-1:0]        in_ready;
    logic [CH*WIDTH-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [CW-1:0]        out_chan;
    logic [CH*LW-1:0]     level;

    dir_chan_merge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_chan(out_chan), .level(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef logic [WIDTH-1:0] word_t;
    word_t mq [CH][$];
    bit    m_ov;
    word_t m_od;
    int    m_oc;
    int    m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < CH; c++) mq[c].delete();
        m_ov = 0; m_od = '0; m_oc = 0; m_last = CH - 1;
    endtask

    // Advances the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic [CH-1:0] rdy;
        bit found;
        int w;
        for (int c = 0; c < CH; c++) rdy[c] = (mq[c].size() != DEPTH);
        if (flush) begin
            model_clear();
        end else begin
            found = 0; w = 0;
            for (int i = 1; i <= CH; i++)
                if (!found && mq[(m_last + i) % CH].size() != 0) begin
                    found = 1; w = (m_last + i) % CH;
                end
            if ((!m_ov || out_ready) && found) begin
                m_od = mq[w].pop_front(); m_oc = w; m_last = w; m_ov = 1;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            for (int c = 0; c < CH; c++)
                if (in_valid[c] && rdy[c]) mq[c].push_back(in_data[c*WIDTH +: WIDTH]);
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, ".out_data"}, 32'(out_data), 32'(m_od));
        chk({tag, ".out_chan"}, 32'(out_chan), 32'(m_oc));
        for (int c = 0; c < CH; c++) begin
            chk({tag, ".level"}, 32'(level[c*LW +: LW]), 32'(mq[c].size()));
            chk({tag, ".in_ready"}, 32'(in_ready[c]), 32'(mq[c].size() != DEPTH));
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        model_check(tag);
    endtask

    task automatic drive(input logic fl, input logic [CH-1:0] iv, input word_t d0, input word_t d1,
                         input logic ordy);
        flush = fl; in_valid = iv; in_data = {d1, d0}; out_ready = ordy;
    endtask

    typedef struct {
        logic [CH-1:0] iv;
        word_t         d0;
        logic          ordy;
        logic          e_ov;
        word_t         e_od;
        logic [LW-1:0] e_lvl0;
        logic [CH-1:0] e_rdy;
    } vec_t;

    vec_t tbl [11];

    initial begin
        word_t exp_seq [6];
        int    exp_ch  [6];

        // Single channel fill to full with the consumer stalled, then drain.
        tbl[0]  = '{2'b01, 8'h11, 1'b0, 1'b0, 8'h00, 3'd1, 2'b11};
        tbl[1]  = '{2'b01, 8'h22, 1'b0, 1'b1, 8'h11, 3'd1, 2'b11};
        tbl[2]  = '{2'b01, 8'h33, 1'b0, 1'b1, 8'h11, 3'd2, 2'b11};
        tbl[3]  = '{2'b01, 8'h44, 1'b0, 1'b1, 8'h11, 3'd3, 2'b11};
        tbl[4]  = '{2'b01, 8'h55, 1'b0, 1'b1, 8'h11, 3'd4, 2'b10};
        tbl[5]  = '{2'b01, 8'h66, 1'b0, 1'b1, 8'h11, 3'd4, 2'b10};
        tbl[6]  = '{2'b00, 8'h00, 1'b1, 1'b1, 8'h22, 3'd3, 2'b11};
        tbl[7]  = '{2'b00, 8'h00, 1'b1, 1'b1, 8'h33, 3'd2, 2'b11};
        tbl[8]  = '{2'b00, 8'h00, 1'b1, 1'b1, 8'h44, 3'd1, 2'b11};
        tbl[9]  = '{2'b00, 8'h00, 1'b1, 1'b1, 8'h55, 3'd0, 2'b11};
        tbl[10] = '{2'b00, 8'h00, 1'b1, 1'b0, 8'h55, 3'd0, 2'b11};

        rst = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0);
        model_clear();
        #2;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_data", 32'(out_data), 32'd0);
        chk("reset.out_chan", 32'(out_chan), 32'd0);
        chk("reset.level", 32'(level), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'(2'b11));
        #1 rst = 1'b0;

        foreach (tbl[i]) begin
            drive(1'b0, tbl[i].iv, tbl[i].d0, 8'h00, tbl[i].ordy);
            tick("tbl");
            chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d.out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            chk($sformatf("tbl%0d.out_chan", i), 32'(out_chan), 32'd0);
            chk($sformatf("tbl%0d.level0", i), 32'(level[0 +: LW]), 32'(tbl[i].e_lvl0));
            chk($sformatf("tbl%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
        end

        // Round-robin: after flush channel 0 has first priority.
        drive(1'b1, '0, '0, '0, 1'b0); tick("rr_flush");
        drive(1'b0, 2'b11, 8'hA0, 8'hB0, 1'b0); tick("rr_p0");
        drive(1'b0, 2'b11, 8'hA1, 8'hB1, 1'b0); tick("rr_p1");
        chk("rr.first_data", 32'(out_data), 32'hA0);
        chk("rr.first_chan", 32'(out_chan), 32'd0);
        drive(1'b0, 2'b11, 8'hA2, 8'hB2, 1'b0); tick("rr_p2");
        exp_seq = '{8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hB2};
        exp_ch  = '{1, 0, 1, 0, 1, 1};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b1); tick("rr_drain");
            chk($sformatf("rr.seq%0d_data", i), 32'(out_data), 32'(exp_seq[i]));
            chk($sformatf("rr.seq%0d_chan", i), 32'(out_chan), 32'(exp_ch[i]));
        end
        tick("rr_empty");
        chk("rr.empty_valid", 32'(out_valid), 32'd0);

        // Backpressure: held output must not move while ch1 pushes.
        drive(1'b0, 2'b01, 8'h5A, 8'h00, 1'b0); tick("bp_push");
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0); tick("bp_load");
        chk("bp.loaded", 32'(out_data), 32'h5A);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b10, 8'h00, word_t'(i + 1), 1'b0); tick("bp_stall");
            chk($sformatf("bp.hold%0d_data", i), 32'(out_data), 32'h5A);
            chk($sformatf("bp.hold%0d_chan", i), 32'(out_chan), 32'd0);
        end
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b1); tick("bp_release");
        chk("bp.next_data", 32'(out_data), 32'h01);
        chk("bp.next_chan", 32'(out_chan), 32'd1);
        for (int i = 0; i < 3; i++) tick("bp_drain");

        // Full FIFO refuses a push in the same cycle it is popped.
        drive(1'b1, '0, '0, '0, 1'b0); tick("fp_flush");
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2'b01, word_t'(8'hC0 + i), 8'h00, 1'b0); tick("fp_fill");
        end
        chk("fp.full_level", 32'(level[0 +: LW]), 32'd4);
        drive(1'b0, 2'b01, 8'hC5, 8'h00, 1'b1);
        #1 chk("fp.ready_low", 32'(in_ready[0]), 32'd0);
        tick("fp_pop");
        chk("fp.level_after_pop", 32'(level[0 +: LW]), 32'd3);
        drive(1'b0, 2'b01, 8'hC5, 8'h00, 1'b0); tick("fp_accept");
        chk("fp.level_after_push", 32'(level[0 +: LW]), 32'd4);

        // Flush with data buffered and a concurrent push on ch1.
        drive(1'b1, '0, '0, '0, 1'b0); tick("fl_flush0");
        drive(1'b0, 2'b11, 8'hD0, 8'hE0, 1'b0); tick("fl_p0");
        drive(1'b0, 2'b11, 8'hD1, 8'hE1, 1'b0); tick("fl_p1");
        drive(1'b0, 2'b11, 8'hD2, 8'hE2, 1'b0); tick("fl_p2");
        chk("fl.pre_level0", 32'(level[0 +: LW]), 32'd2);
        chk("fl.pre_level1", 32'(level[LW +: LW]), 32'd3);
        chk("fl.pre_valid", 32'(out_valid), 32'd1);
        drive(1'b1, 2'b10, 8'h00, 8'hEE, 1'b0); tick("fl_flush");
        chk("fl.level", 32'(level), 32'd0);
        chk("fl.valid", 32'(out_valid), 32'd0);
        drive(1'b0, 2'b11, 8'hF0, 8'hF1, 1'b0); tick("fl_push");
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0); tick("fl_load");
        chk("fl.first_data", 32'(out_data), 32'hF0);
        chk("fl.first_chan", 32'(out_chan), 32'd0);
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b1); tick("fl_second");
        chk("fl.second_data", 32'(out_data), 32'hF1);
        tick("fl_done");

        // Asynchronous reset mid-stream, checked without a clock edge.
        drive(1'b0, 2'b11, 8'h71, 8'h72, 1'b0); tick("ar_p0");
        drive(1'b0, 2'b11, 8'h73, 8'h74, 1'b0); tick("ar_p1");
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("areset.out_valid", 32'(out_valid), 32'd0);
        chk("areset.level", 32'(level), 32'd0);
        chk("areset.in_ready", 32'(in_ready), 32'(2'b11));
        model_clear();
        #1 rst = 1'b0;
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick("ar_idle");
            chk("areset.idle_valid", 32'(out_valid), 32'd0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 63) == 0), CH'($urandom), word_t'($urandom), word_t'($urandom),
                  ($urandom_range(0, 3) != 0));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
